// File: rtl/led_reg_init_sequencer_if.sv
// AXI4-Lite bundle between the register-init sequencer (master) and the
// LED peripheral's S00_AXI register bank (slave).
interface led_reg_init_sequencer_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/led_reg_init_sequencer.sv
// Writes an incrementing pattern into NUM_REGS consecutive AXI4-Lite registers,
// reads them all back, and reports pass/fail plus a saturating error count.
module led_reg_init_sequencer #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          NUM_REGS   = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          ERR_WIDTH  = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     start,
  input  logic [31:0]              seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_WIDTH-1:0]     err_cnt,
  led_reg_init_sequencer_if.master m_axi
);

  localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [1:0]       RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FINISH
  } state_e;

  state_e                state_q,   state_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [31:0]           seed_q,    seed_d;
  logic [ERR_WIDTH-1:0]  err_q,     err_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  pass_q,    pass_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [31:0]           wdata_q,   wdata_d;

  logic [IDX_W-1:0]     idx_next;
  logic                 is_last;
  logic [ERR_WIDTH-1:0] err_inc;
  logic                 rd_bad;

  function automatic logic [ADDR_WIDTH-1:0] regAddr(input logic [IDX_W-1:0] i);
    logic [31:0] a;
    a = BASE_ADDR + (32'(i) << 2);
    return a[ADDR_WIDTH-1:0];
  endfunction

  assign idx_next = idx_q + IDX_W'(1);
  assign is_last  = (idx_q == LAST_IDX);
  assign err_inc  = (&err_q) ? err_q : err_q + ERR_WIDTH'(1);
  // A read beat with both a bad response and bad data still counts as one error.
  assign rd_bad   = (m_axi.rresp != RESP_OKAY) || (m_axi.rdata != seed_q + 32'(idx_q));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seed_d    = seed_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          seed_d    = seed;
          err_d     = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          idx_d     = '0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = regAddr('0);
          wdata_d   = seed;
          state_d   = WR_REQ;
        end
      end

      // AW and W channels retire independently; leave once neither is still pending.
      WR_REQ: begin
        if (m_axi.awready) awvalid_d = 1'b0;
        if (m_axi.wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != RESP_OKAY) err_d = err_inc;
          if (is_last) begin
            idx_d     = '0;
            arvalid_d = 1'b1;
            araddr_d  = regAddr('0);
            state_d   = RD_REQ;
          end else begin
            idx_d     = idx_next;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = regAddr(idx_next);
            wdata_d   = seed_q + 32'(idx_next);
            state_d   = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (m_axi.rvalid) begin
          if (rd_bad) err_d = err_inc;
          if (is_last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
            state_d = FINISH;
          end else begin
            idx_d     = idx_next;
            arvalid_d = 1'b1;
            araddr_d  = regAddr(idx_next);
            state_d   = RD_REQ;
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      seed_q    <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seed_q    <= seed_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = (state_q == WR_RESP);
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state_q == RD_RESP);

endmodule

// File: tb/tb_led_reg_init_sequencer.sv
// Randomized scoreboard bench: a reactive AXI4-Lite slave, a protocol/data
// monitor and a spec-level model of the expected error count.
`timescale 1ns/1ps
module tb_led_reg_init_sequencer;

  localparam int AW     = 4;
  localparam int NREGS  = 4;
  localparam int EW     = 8;
  localparam int BUDGET = 2000;

  typedef struct {
    logic [EW-1:0] err;
    logic          pass;
  } res_t;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          start;
  logic [31:0]   seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_cnt;

  led_reg_init_sequencer_if #(.ADDR_WIDTH(AW)) axi ();

  led_reg_init_sequencer #(
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NREGS),
    .BASE_ADDR (32'h0),
    .ERR_WIDTH (EW)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .start  (start),
    .seed   (seed),
    .busy   (busy),
    .done   (done),
    .pass   (pass),
    .err_cnt(err_cnt),
    .m_axi  (axi)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] expAw[$];
  logic [31:0]   expW[$];
  logic [AW-1:0] expAr[$];
  res_t          expRes[$];

  // Slave behaviour knobs: delays of -1 mean random 0..3 per transaction,
  // fault registers of -1 mean no fault injected.
  int awDly, wDly, arDly, bLat, rLat;
  int bFaultReg, rdFaultReg, rrFaultReg;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int cfg);
    return (cfg >= 0) ? cfg : int'($urandom_range(0, 3));
  endfunction

  task automatic setCfg(input int a, input int w, input int ar, input int b, input int r,
                        input int bf, input int rdf, input int rrf);
    awDly = a; wDly = w; arDly = ar; bLat = b; rLat = r;
    bFaultReg = bf; rdFaultReg = rdf; rrFaultReg = rrf;
  endtask

  // Register i should read back what was written (seed+i) unless the slave
  // corrupts it; any bad write response or bad read beat is one error each.
  function automatic int modelErrs(input logic [31:0] s);
    int e;
    logic [31:0] want, got;
    e = 0;
    for (int i = 0; i < NREGS; i++) begin
      want = s + 32'(i);
      got  = (i == rdFaultReg) ? 32'hDEAD : want;
      if (i == bFaultReg) e++;
      if ((got != want) || (i == rrFaultReg)) e++;
    end
    return (e > 255) ? 255 : e;
  endfunction

  task automatic flushScoreboard();
    expAw.delete();
    expW.delete();
    expAr.delete();
    expRes.delete();
  endtask

  task automatic applyStimulus(input logic [31:0] s);
    res_t r;
    int   e;
    for (int i = 0; i < NREGS; i++) begin
      expAw.push_back(AW'(4 * i));
      expW.push_back(s + 32'(i));
      expAr.push_back(AW'(4 * i));
    end
    e      = modelErrs(s);
    r.err  = EW'(e);
    r.pass = (e == 0);
    expRes.push_back(r);
    @(posedge ACLK); #1;
    seed  = s;
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    seed  = $urandom;
  endtask

  task automatic checkReset();
    checkOutput("rst_busy",    32'(busy), 0);
    checkOutput("rst_done",    32'(done), 0);
    checkOutput("rst_pass",    32'(pass), 0);
    checkOutput("rst_err",     32'(err_cnt), 0);
    checkOutput("rst_valids",  32'({axi.awvalid, axi.wvalid, axi.arvalid}), 0);
    checkOutput("rst_readies", 32'({axi.bready, axi.rready}), 0);
    checkOutput("rst_awaddr",  32'(axi.awaddr), 0);
    checkOutput("rst_araddr",  32'(axi.araddr), 0);
    checkOutput("rst_wdata",   axi.wdata, 0);
  endtask

  task automatic runAndCheck(input logic [31:0] s, input bit startInRd);
    bit ok;
    int e;
    e = modelErrs(s);
    applyStimulus(s);
    if (startInRd) begin
      ok = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
        @(negedge ACLK);
        if (axi.arvalid) begin ok = 1'b1; break; end
      end
      checkOutput("ar_seen", 32'(ok), 1);
      start = 1'b1;
      seed  = ~s;
      @(posedge ACLK); #1;
      start = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge ACLK);
      if (done) begin ok = 1'b1; break; end
    end
    checkOutput("done_seen", 32'(ok), 1);
    repeat (3) @(negedge ACLK);
    checkOutput("busy_after",  32'(busy), 0);
    checkOutput("done_after",  32'(done), 0);
    checkOutput("pass_held",   32'(pass), 32'(e == 0));
    checkOutput("err_held",    32'(err_cnt), 32'(e));
    checkOutput("sb_leftover", 32'(expAw.size() + expW.size() + expAr.size() + expRes.size()), 0);
    flushScoreboard();
  endtask

  // Reactive slave: sample handshakes at the falling edge, act 1ns after the rising edge.
  initial begin : slave
    logic          sAw, sW, sB, sAr, sR;
    logic [AW-1:0] sAwAddr, sArAddr, wrAddr, rdAddr;
    logic [31:0]   sWData, wrData;
    logic          gotAw, gotW, bPend, rPend, awArm, wArm, arArm;
    int            awCnt, wCnt, arCnt, bCnt, rCnt, awD, wD, arD;
    logic [31:0]   mem [NREGS];
    logic [1:0]    ri;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid  = 1'b0; axi.rvalid = 1'b0; axi.bresp = 2'b00;
    axi.rresp   = 2'b00; axi.rdata = 32'h0;
    for (int i = 0; i < NREGS; i++) mem[i] = 32'h0;
    gotAw = 0; gotW = 0; bPend = 0; rPend = 0; awArm = 0; wArm = 0; arArm = 0;
    awCnt = 0; wCnt = 0; arCnt = 0; bCnt = 0; rCnt = 0; awD = 0; wD = 0; arD = 0;
    wrAddr = '0; rdAddr = '0; wrData = '0;
    forever begin
      @(negedge ACLK);
      sAw = axi.awvalid & axi.awready; sAwAddr = axi.awaddr;
      sW  = axi.wvalid & axi.wready;   sWData  = axi.wdata;
      sB  = axi.bvalid & axi.bready;
      sAr = axi.arvalid & axi.arready; sArAddr = axi.araddr;
      sR  = axi.rvalid & axi.rready;
      @(posedge ACLK); #1;
      if (ARESET) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid  = 1'b0; axi.rvalid = 1'b0;
        gotAw = 0; gotW = 0; bPend = 0; rPend = 0; awArm = 0; wArm = 0; arArm = 0;
        awCnt = 0; wCnt = 0; arCnt = 0;
      end else begin
        if (sAw) begin gotAw = 1; wrAddr = sAwAddr; awCnt = 0; awArm = 0; end
        if (sW)  begin gotW = 1;  wrData = sWData;  wCnt = 0;  wArm = 0;  end
        if (sB)  axi.bvalid = 1'b0;
        if (sR)  axi.rvalid = 1'b0;
        if (sAr) begin rdAddr = sArAddr; rPend = 1; rCnt = pick(rLat); arCnt = 0; arArm = 0; end
        if (gotAw && gotW) begin
          mem[wrAddr[3:2]] = wrData;
          axi.bresp = (int'(wrAddr[3:2]) == bFaultReg) ? 2'b10 : 2'b00;
          gotAw = 0; gotW = 0; bPend = 1; bCnt = pick(bLat);
        end
        if (bPend) begin
          if (bCnt == 0) begin axi.bvalid = 1'b1; bPend = 0; end
          else bCnt--;
        end
        if (rPend) begin
          if (rCnt == 0) begin
            ri         = rdAddr[3:2];
            axi.rdata  = (int'(ri) == rdFaultReg) ? 32'hDEAD : mem[ri];
            axi.rresp  = (int'(ri) == rrFaultReg) ? 2'b10 : 2'b00;
            axi.rvalid = 1'b1;
            rPend      = 0;
          end else rCnt--;
        end
        if (axi.awvalid && !awArm) begin awD = pick(awDly); awArm = 1; end
        if (axi.wvalid  && !wArm)  begin wD  = pick(wDly);  wArm  = 1; end
        if (axi.arvalid && !arArm) begin arD = pick(arDly); arArm = 1; end
        axi.awready = axi.awvalid && (awCnt >= awD);
        axi.wready  = axi.wvalid  && (wCnt  >= wD);
        axi.arready = axi.arvalid && (arCnt >= arD);
        if (axi.awvalid && !axi.awready) awCnt++;
        if (axi.wvalid  && !axi.wready)  wCnt++;
        if (axi.arvalid && !axi.arready) arCnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and done pulse, and checks
  // channel stability, valid drop-off and single-outstanding ordering.
  initial begin : monitor
    logic          awGot, wGot, arGot;
    logic          pAwWait, pWWait, pArWait, pAwHs, pWHs, pArHs;
    logic [AW-1:0] pAwAddr, pArAddr;
    logic [31:0]   pWData;
    res_t          r;
    awGot = 0; wGot = 0; arGot = 0;
    pAwWait = 0; pWWait = 0; pArWait = 0; pAwHs = 0; pWHs = 0; pArHs = 0;
    pAwAddr = '0; pArAddr = '0; pWData = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        awGot = 0; wGot = 0; arGot = 0;
        pAwWait = 0; pWWait = 0; pArWait = 0; pAwHs = 0; pWHs = 0; pArHs = 0;
        continue;
      end
      if (pAwWait) checkOutput("aw_hold", {27'b0, axi.awvalid, axi.awaddr}, {27'b0, 1'b1, pAwAddr});
      if (pArWait) checkOutput("ar_hold", {27'b0, axi.arvalid, axi.araddr}, {27'b0, 1'b1, pArAddr});
      if (pWWait) begin
        checkOutput("w_hold_valid", 32'(axi.wvalid), 1);
        checkOutput("w_hold_data",  axi.wdata, pWData);
      end
      if (pAwHs) checkOutput("aw_drop", 32'(axi.awvalid), 0);
      if (pWHs)  checkOutput("w_drop",  32'(axi.wvalid), 0);
      if (pArHs) checkOutput("ar_drop", 32'(axi.arvalid), 0);

      if (axi.awvalid && axi.awready) begin
        checkOutput("aw_single", 32'(awGot), 0);
        awGot = 1;
        checkOutput("aw_expected", 32'(expAw.size() != 0), 1);
        if (expAw.size() != 0) checkOutput("awaddr", 32'(axi.awaddr), 32'(expAw.pop_front()));
      end
      if (axi.wvalid && axi.wready) begin
        checkOutput("w_single", 32'(wGot), 0);
        wGot = 1;
        checkOutput("wstrb", 32'(axi.wstrb), 32'hF);
        checkOutput("w_expected", 32'(expW.size() != 0), 1);
        if (expW.size() != 0) checkOutput("wdata", axi.wdata, expW.pop_front());
      end
      if (axi.bvalid && axi.bready) begin
        checkOutput("b_order", 32'({awGot, wGot}), 32'b11);
        awGot = 0; wGot = 0;
      end
      if (axi.arvalid && axi.arready) begin
        checkOutput("ar_order", 32'({awGot, wGot, arGot}), 0);
        arGot = 1;
        checkOutput("ar_expected", 32'(expAr.size() != 0), 1);
        if (expAr.size() != 0) checkOutput("araddr", 32'(axi.araddr), 32'(expAr.pop_front()));
      end
      if (axi.rvalid && axi.rready) begin
        checkOutput("r_order", 32'(arGot), 1);
        arGot = 0;
      end
      if (done) begin
        checkOutput("done_expected", 32'(expRes.size() != 0), 1);
        checkOutput("done_busy", 32'(busy), 0);
        if (expRes.size() != 0) begin
          r = expRes.pop_front();
          checkOutput("done_err",  32'(err_cnt), 32'(r.err));
          checkOutput("done_pass", 32'(pass), 32'(r.pass));
        end
      end

      pAwWait = axi.awvalid && !axi.awready; pAwAddr = axi.awaddr;
      pWWait  = axi.wvalid  && !axi.wready;  pWData  = axi.wdata;
      pArWait = axi.arvalid && !axi.arready; pArAddr = axi.araddr;
      pAwHs   = axi.awvalid && axi.awready;
      pWHs    = axi.wvalid  && axi.wready;
      pArHs   = axi.arvalid && axi.arready;
    end
  end

  initial begin : main
    bit          ok;
    logic [31:0] s;
    ARESET = 1'b1;
    start  = 1'b0;
    seed   = 32'h0;
    setCfg(0, 0, 0, 0, 0, -1, -1, -1);
    repeat (3) @(negedge ACLK);
    checkReset();
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    $display("[TB] ideal slave, seed=1");
    runAndCheck(32'h1, 1'b0);

    $display("[TB] awready delayed 3 cycles");
    setCfg(3, 0, 0, 0, 0, -1, -1, -1);
    runAndCheck(32'h0000_0100, 1'b0);

    $display("[TB] rdata corrupted at 0x8");
    setCfg(0, 0, 0, 0, 0, -1, 2, -1);
    runAndCheck(32'h1, 1'b0);

    $display("[TB] SLVERR on register 1 write");
    setCfg(0, 0, 0, 0, 0, 1, -1, -1);
    runAndCheck(32'h1, 1'b0);

    $display("[TB] start pulsed during RD_REQ");
    setCfg(0, 0, 2, 0, 0, -1, -1, -1);
    runAndCheck(32'hCAFE_0000, 1'b1);

    $display("[TB] seed wrap-around");
    setCfg(-1, -1, -1, -1, -1, -1, -1, -1);
    runAndCheck(32'hFFFF_FFFE, 1'b0);

    $display("[TB] reset during RD_RESP");
    setCfg(0, 0, 0, 0, 3, -1, -1, -1);
    applyStimulus(32'h55);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge ACLK);
      if (axi.rready) begin ok = 1'b1; break; end
    end
    checkOutput("rd_resp_seen", 32'(ok), 1);
    ARESET = 1'b1;
    #1;
    checkReset();
    flushScoreboard();
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    setCfg(0, 0, 0, 0, 0, -1, -1, -1);
    runAndCheck(32'h10, 1'b0);

    $display("[TB] randomized runs");
    for (int k = 0; k < 16; k++) begin
      setCfg(-1, -1, -1, -1, -1,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
      s = $urandom;
      runAndCheck(s, (k % 5) == 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_reg_init_sequencer.md
Name:
led_reg_init_sequencer

Overview:
- AXI4-Lite master controller that initialises and then verifies the LED peripheral's slave register bank.
- On a start pulse it writes NUM_REGS consecutive 32-bit registers with an incrementing pattern. It then reads each register back and compares it with the pattern.
- It reports completion, pass/fail and an error count.
- Sits between system control logic and the LED peripheral's S00_AXI port.

Parameters:
- ADDR_WIDTH, 4, AXI address width in bits. Must be at least clog2(4*NUM_REGS).
- NUM_REGS, 4, number of registers written and read back. Legal range 1..16.
- BASE_ADDR, 0, byte address of register 0. Register i is at BASE_ADDR + 4*i.
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- ACLK  in  1  clock; all logic is rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run the sequence.
- seed  in  32  pattern start value; sampled when start is accepted.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the sequence completes.
- pass  out  1  high when the last sequence had err_cnt==0; held until the next start.
- err_cnt  out  ERR_WIDTH  mismatch/error count of the last sequence, saturating.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  byte strobes; always 4'hF.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  ADDR_WIDTH  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset (ARESET high, asynchronous):
  - all valid/ready outputs, busy, done and pass are 0; err_cnt is 0; addresses and wdata are 0.
  - State is IDLE and the index is 0.
- States are IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH.
- IDLE:
  - start=1 latches seed, clears err_cnt and pass, sets busy, index i=0, and moves to WR_REQ on the next edge.
  - start while busy is ignored.
- WR_REQ:
  - awvalid and wvalid assert together with awaddr=BASE_ADDR+4*i and wdata=seed+i (mod 2^32).
  - Each valid drops on the cycle after its own handshake (valid&ready). AW and W complete independently, in either order or together.
  - Address and data stay stable while the corresponding valid is high.
  - Once both handshakes have completed, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: bresp!=OKAY increments err_cnt.
  - If i==NUM_REGS-1, set i=0 and go to RD_REQ; otherwise i++ and go to WR_REQ.
- RD_REQ:
  - arvalid=1 with araddr=BASE_ADDR+4*i, held stable until arready.
  - After the handshake, arvalid drops and the state moves to RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: increment err_cnt once if rresp!=OKAY or rdata!=seed+i. Both faults in one beat still count 1.
  - If i==NUM_REGS-1 go to FINISH; otherwise i++ and go to RD_REQ.
- FINISH (one cycle):
  - done=1, busy drops to 0 on the same edge, pass=(err_cnt==0).
  - Return to IDLE.
- Ordering and counter rules:
  - Only one transaction is outstanding at a time; a read never starts before the last B response.
  - err_cnt saturates at all-ones.
- Reset mid-operation: all outputs return immediately to their reset values. The slave must be reset in the same domain. No partial result is reported, and the next start runs the full sequence.
- Timing with an always-ready slave that responds one cycle after the handshake: each write takes 3 cycles and each read takes 3 cycles.

Test Plan:
- seed=1, NUM_REGS=4, ideal slave:
  - writes go to 0x0/0x4/0x8/0xC with data 1/2/3/4, then reads return 1..4.
  - Required response: done pulses once, pass=1, err_cnt=0, busy low after done.
- awready delayed 3 cycles, wready immediate:
  - wvalid drops after one cycle; awvalid and awaddr are held stable 3 cycles.
  - No new AW/W is issued before bready & bvalid.
- Slave returns rdata=0xDEAD at address 0x8, seed=1:
  - err_cnt=1, pass=0, all 4 reads still issued.
- bresp=SLVERR on register 1 write:
  - err_cnt=1, and the read phase still runs for all 4 registers.
- start pulsed again during RD_REQ:
  - ignored; exactly 4 reads, one done pulse.
- ARESET asserted during RD_RESP:
  - all valids and busy go 0 in the same cycle.
  - A later start with seed=0x10 produces writes 0x10..0x13 and pass=1.
